neuron_bus_receiver: RTL and testbench
======================================

NEURON_BUS_RECEIVER -- requirements
Module: neuron_bus_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of DATA_BUS, threshold words and each packed input/weight word.
REQ-002 SHALL have parameter N_PAIRS, default 32: number of input/weight word pairs per frame; a frame is 2*N_PAIRS+2 = 66 words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port chip_sel, input, 1 bit: frame select from the generator, high for the whole frame transfer.
REQ-006 SHALL have port wr_en, input, 1 bit: word strobe; a write is any cycle with chip_sel=1 and wr_en=1.
REQ-007 SHALL have port DATA_BUS, input, DATA_WIDTH bits: write data, sampled on the write edge.
REQ-008 SHALL have port output_ready, output, 1 bit: result valid.
REQ-009 SHALL have port neuron_level, output, 2 bits: classification result, 0, 1 or 2.
REQ-010 SHALL have port popcount_sum, output, 10 bits: total XNOR match count, range 0..512.
REQ-011 SHALL have port protocol_err, output, 1 bit: sticky frame error flag.
REQ-012 SHALL have port busy, output, 1 bit: high in LOAD, COMPUTE and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, COMPUTE, DONE.
REQ-014 Word order SHALL be: words 0..31 input vectors, words 32..63 weight vectors, word 64 threshold T0, word 65 threshold T1; word_cnt is 7 bits.
REQ-015 IDLE: first write SHALL store word 0, clear protocol_err, set word_cnt=1 and enter LOAD.
REQ-016 LOAD: each write SHALL store DATA_BUS at word_cnt and increment it; back-to-back writes SHALL be accepted; idle gaps of any length SHALL be tolerated.
REQ-017 The write storing word 65 SHALL enter COMPUTE with pair index 0 and accumulator 0.
REQ-018 COMPUTE: each cycle SHALL add popcount(~(in[i] ^ w[i])) to a 10-bit accumulator, one pair per cycle, for i=0..31.
REQ-019 After pair 31, the next edge SHALL register popcount_sum and neuron_level, set output_ready=1 and enter DONE; output_ready SHALL first be high 33 clock edges after the word-65 write edge.
REQ-020 Classification SHALL use zero-extended unsigned compares with T1 taking priority: sum>=T1 gives level 2, else sum>=T0 gives level 1, else level 0.
REQ-021 DONE: output_ready and the results SHALL hold until chip_sel=0, then the FSM SHALL enter IDLE and clear output_ready the same edge; results SHALL stay stable until the next frame's COMPUTE completes.
REQ-022 chip_sel=0 in LOAD SHALL set protocol_err, clear word_cnt, enter IDLE and produce no output_ready.
REQ-023 Writes in COMPUTE or DONE SHALL be ignored, SHALL set protocol_err, and SHALL NOT alter stored words or results.
REQ-024 chip_sel=1 without wr_en SHALL have no effect in any state.

Reset
REQ-025 While reset=1, outputs SHALL be: output_ready=0, neuron_level=0, popcount_sum=0, protocol_err=0, busy=0; FSM=IDLE; word_cnt, pair index and accumulator SHALL be 0.
REQ-026 Reset asserted mid-frame or mid-COMPUTE SHALL abort immediately; no result SHALL be produced for that frame; word storage need not be cleared.

Structure
REQ-027 Package neuron_pkg SHALL hold the FSM state typedef, N_WORDS=66, N_PAIRS=32 and the T0/T1 word indices, shared with the generator side.
REQ-028 Sub-module xnor_popcount16 (combinational, two 16-bit inputs, 5-bit count) SHALL compute the per-pair match count.

Verification
REQ-029 Inputs and weights all 0xFFFF, T0=100, T1=400 -> popcount_sum=512, neuron_level=2, output_ready at word-65 edge+33.
REQ-030 Inputs 0xFFFF, weights 0x0000, T0=1 -> popcount_sum=0, neuron_level=0.
REQ-031 Inputs 0xAAAA; weights 0xAAAA for pairs 0..15 and 0x5555 for pairs 16..31; T0=256, T1=257 -> sum=256, level=1 (equality boundary).
REQ-032 chip_sel dropped after 40 writes -> protocol_err=1, IDLE, no output_ready; the next full frame clears protocol_err and completes correctly.
REQ-033 Extra write during COMPUTE -> protocol_err=1, result identical to an unperturbed run; drop chip_sel in DONE -> output_ready=0 the next edge.
REQ-034 reset pulsed at COMPUTE pair 10 -> all outputs 0 immediately; a subsequent full frame yields the correct result.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron bus receiver and the frame generator side.
package neuron_pkg;

    localparam int N_PAIRS = 32;
    localparam int N_WORDS = 2 * N_PAIRS + 2;
    localparam int T0_IDX  = 2 * N_PAIRS;
    localparam int T1_IDX  = 2 * N_PAIRS + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } nrx_state_t;

endpackage

// File: rtl/xnor_popcount16.sv
// Per-pair binary-neuron match count: number of bit positions where a and b agree.
module xnor_popcount16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [4:0]  count
);

    logic [15:0] match;

    always_comb begin
        match = ~(a ^ b);
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(match[i]);
        end
    end

endmodule

// File: rtl/neuron_bus_receiver.sv
// Receives a 66-word frame (inputs, weights, T0, T1), accumulates XNOR matches
// one pair per cycle and classifies the total against the two thresholds.
module neuron_bus_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int N_PAIRS    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_sel,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] DATA_BUS,
    output logic                  output_ready,
    output logic [1:0]            neuron_level,
    output logic [9:0]            popcount_sum,
    output logic                  protocol_err,
    output logic                  busy
);
    import neuron_pkg::*;

    localparam int WORDS  = 2 * N_PAIRS + 2;
    localparam int T0_POS = 2 * N_PAIRS;
    localparam int T1_POS = 2 * N_PAIRS + 1;

    nrx_state_t state, next_state;

    logic [DATA_WIDTH-1:0] words [0:WORDS-1];
    logic [6:0]            word_cnt;
    logic [5:0]            pair_idx;
    logic [9:0]            acc;
    logic [4:0]            pair_count;
    logic [1:0]            level_next;
    logic                  write;
    logic                  store_en;
    logic [6:0]            store_idx;

    assign write     = chip_sel & wr_en;
    assign store_en  = write & ((state == IDLE) | (state == LOAD));
    assign store_idx = (state == IDLE) ? 7'd0 : word_cnt;
    assign busy      = (state != IDLE);

    // Frame storage is deliberately not reset; every frame overwrites it fully.
    always_ff @(posedge clk) begin
        if (store_en) words[store_idx] <= DATA_BUS;
    end

    xnor_popcount16 u_pop (
        .a     (words[{1'b0, pair_idx}]),
        .b     (words[7'(N_PAIRS) + {1'b0, pair_idx}]),
        .count (pair_count)
    );

    always_comb begin
        level_next = 2'd0;
        if (DATA_WIDTH'(acc) >= words[T1_POS])      level_next = 2'd2;
        else if (DATA_WIDTH'(acc) >= words[T0_POS]) level_next = 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (write) next_state = LOAD;
            LOAD: begin
                if (!chip_sel)                                     next_state = IDLE;
                else if (write && word_cnt == 7'(WORDS - 1))       next_state = COMPUTE;
            end
            COMPUTE: if (pair_idx == 6'(N_PAIRS)) next_state = DONE;
            DONE:    if (!chip_sel) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt     <= '0;
            pair_idx     <= '0;
            acc          <= '0;
            output_ready <= 1'b0;
            neuron_level <= 2'd0;
            popcount_sum <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        word_cnt     <= 7'd1;
                        protocol_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!chip_sel) begin
                        protocol_err <= 1'b1;
                        word_cnt     <= '0;
                    end else if (write) begin
                        if (word_cnt == 7'(WORDS - 1)) begin
                            word_cnt <= '0;
                            pair_idx <= '0;
                            acc      <= '0;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end
                end
                COMPUTE: begin
                    // pair_idx == N_PAIRS is the extra cycle that publishes the result
                    if (pair_idx == 6'(N_PAIRS)) begin
                        popcount_sum <= acc;
                        neuron_level <= level_next;
                        output_ready <= 1'b1;
                    end else begin
                        acc      <= acc + 10'(pair_count);
                        pair_idx <= pair_idx + 6'd1;
                    end
                    if (write) protocol_err <= 1'b1;
                end
                DONE: begin
                    if (!chip_sel) output_ready <= 1'b0;
                    if (write)     protocol_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_bus_receiver.sv
// Randomized frame bench for neuron_bus_receiver against a plain-arithmetic model.
module tb_neuron_bus_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        chip_sel;
    logic        wr_en;
    logic [15:0] DATA_BUS;
    logic        output_ready;
    logic [1:0]  neuron_level;
    logic [9:0]  popcount_sum;
    logic        protocol_err;
    logic        busy;

    neuron_bus_receiver #(.DATA_WIDTH(16), .N_PAIRS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .chip_sel     (chip_sel),
        .wr_en        (wr_en),
        .DATA_BUS     (DATA_BUS),
        .output_ready (output_ready),
        .neuron_level (neuron_level),
        .popcount_sum (popcount_sum),
        .protocol_err (protocol_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] in_v [32];
    logic [15:0] w_v  [32];
    logic [15:0] t0, t1;
    int          hold_sum;
    int          hold_lvl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < 32; i++) s += 16 - $countones(in_v[i] ^ w_v[i]);
        return s;
    endfunction

    function automatic int model_level(input int s);
        if (s >= int'(t1)) return 2;
        if (s >= int'(t0)) return 1;
        return 0;
    endfunction

    function automatic logic [15:0] frame_word(input int i);
        if (i < 32) return in_v[i];
        if (i < 64) return w_v[i - 32];
        if (i == 64) return t0;
        return t1;
    endfunction

    task automatic do_write(input logic [15:0] d);
        chip_sel = 1'b1;
        wr_en    = 1'b1;
        DATA_BUS = d;
        @(posedge clk); #1;
        wr_en    = 1'b0;
        DATA_BUS = 16'($urandom);
    endtask

    task automatic load_words(input int cnt, input int gap_max);
        for (int i = 0; i < cnt; i++) begin
            chip_sel = 1'b1;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
            do_write(frame_word(i));
            if (i == 0) begin
                chk("err_clear_first_word", protocol_err, 0);
                chk("busy_load", busy, 1);
            end
        end
    endtask

    task automatic run_frame(input int gap_max, input bit poke);
        int s, lvl, n, poke_at;
        s   = model_sum();
        lvl = model_level(s);
        load_words(66, gap_max);
        poke_at = poke ? int'($urandom_range(1, 32)) : 0;
        n = 0;
        while (n < 100) begin
            if (poke && n + 1 == poke_at) begin
                DATA_BUS = 16'($urandom);
                wr_en    = 1'b1;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            n++;
            if (n == 1) chk("sum_held_compute", popcount_sum, hold_sum);
            if (output_ready) break;
        end
        chk("ready_latency", n, 33);
        chk("sum", popcount_sum, s);
        chk("level", neuron_level, lvl);
        chk("protocol_err", protocol_err, poke);
        chk("busy_done", busy, 1);
        hold_sum = s;
        hold_lvl = lvl;
        repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
        end
        chk("ready_hold", output_ready, 1);
        if (poke) begin
            do_write(16'($urandom));
            chk("err_done_write", protocol_err, 1);
            chk("sum_done_write", popcount_sum, hold_sum);
            chk("level_done_write", neuron_level, hold_lvl);
            chk("ready_done_write", output_ready, 1);
        end
        chip_sel = 1'b0;
        @(posedge clk); #1;
        chk("ready_drop", output_ready, 0);
        chk("busy_idle", busy, 0);
        chk("sum_after_drop", popcount_sum, hold_sum);
    endtask

    task automatic random_data();
        for (int i = 0; i < 32; i++) begin
            in_v[i] = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w_v[i] = in_v[i];
                1: w_v[i] = ~in_v[i];
                2: w_v[i] = in_v[i] ^ 16'($urandom & $urandom);
                default: w_v[i] = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        int s, seen;
        reset    = 1'b1;
        chip_sel = 1'b0;
        wr_en    = 1'b0;
        DATA_BUS = '0;
        hold_sum = 0;
        hold_lvl = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", output_ready, 0);
        chk("rst_level", neuron_level, 0);
        chk("rst_sum", popcount_sum, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) begin in_v[i] = 16'hFFFF; w_v[i] = 16'hFFFF; end
        t0 = 16'd100; t1 = 16'd400;
        run_frame(0, 1'b0);
        chk("all_ones_sum", popcount_sum, 512);
        chk("all_ones_level", neuron_level, 2);

        for (int i = 0; i < 32; i++) begin in_v[i] = 16'hFFFF; w_v[i] = 16'h0000; end
        t0 = 16'd1; t1 = 16'd2;
        run_frame(2, 1'b0);
        chk("no_match_sum", popcount_sum, 0);
        chk("no_match_level", neuron_level, 0);

        for (int i = 0; i < 32; i++) begin
            in_v[i] = 16'hAAAA;
            w_v[i]  = (i < 16) ? 16'hAAAA : 16'h5555;
        end
        t0 = 16'd256; t1 = 16'd257;
        run_frame(1, 1'b0);
        chk("boundary_sum", popcount_sum, 256);
        chk("boundary_level", neuron_level, 1);

        // Frame aborted after 40 words
        random_data();
        load_words(40, 2);
        chip_sel = 1'b0;
        @(posedge clk); #1;
        chk("drop_err", protocol_err, 1);
        chk("drop_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (output_ready) seen = 1;
        end
        chk("drop_no_ready", seen, 0);
        chk("drop_sum_held", popcount_sum, hold_sum);
        t0 = 16'd150; t1 = 16'd300;
        run_frame(1, 1'b0);

        random_data();
        s = model_sum();
        t0 = 16'(s); t1 = 16'(s + 1);
        run_frame(1, 1'b1);

        // Reset at pair 10 of COMPUTE
        random_data();
        t0 = 16'd200; t1 = 16'd330;
        load_words(66, 1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ready", output_ready, 0);
        chk("midrst_level", neuron_level, 0);
        chk("midrst_sum", popcount_sum, 0);
        chk("midrst_err", protocol_err, 0);
        chk("midrst_busy", busy, 0);
        chip_sel = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        hold_sum = 0;
        hold_lvl = 0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (output_ready) seen = 1;
        end
        chk("midrst_no_ready", seen, 0);
        run_frame(0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            random_data();
            s = model_sum();
            if ($urandom_range(0, 1) == 1) begin
                t0 = 16'($urandom_range(0, 600));
                t1 = 16'($urandom_range(0, 600));
            end else begin
                t0 = 16'(s + int'($urandom_range(0, 4)) - 2);
                t1 = 16'(int'(t0) + int'($urandom_range(0, 3)));
            end
            run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
